// File: rtl/dphy_pkg.sv
// Shared D-PHY HS transmit definitions: idle levels, polarity default,
// and the order in which the two bits of a DDR period go on the wire.
package dphy_pkg;

    // Pad levels while the lane is not in HS drive.
    localparam logic IDLE_DP_DEF = 1'b0;
    localparam logic IDLE_DN_DEF = 1'b0;

    // Lane polarity: 0 = Dp carries the data, 1 = Dp/Dn exchanged.
    localparam bit SWAP_PN_DEF = 1'b0;

    // Which serializer bit owns the first (rising-edge) half-period.
    typedef enum logic {
        B1_FIRST = 1'b0,
        B2_FIRST = 1'b1
    } ddr_order_e;

    localparam ddr_order_e DDR_ORDER = B1_FIRST;

    // XOR DDR encoding: each edge register stores its bit folded with the
    // opposite-edge register, so r_p ^ r_n equals the newest captured bit.
    function automatic logic ddr_enc(input logic bit_in, input logic other_q);
        return bit_in ^ other_q;
    endfunction

endpackage

// File: rtl/ddr_edge_reg.sv
// Single-bit DDR half register: async active-low clear, clocked on the edge
// chosen by RISE. When ld_en is high it captures d, otherwise it loads 0 so
// a disabled lane never keeps stale data around.
module ddr_edge_reg #(
    parameter bit RISE = 1'b1
) (
    input  logic clk,
    input  logic clr_n,
    input  logic ld_en,
    input  logic d,
    output logic q
);

    generate
        if (RISE) begin : g_rise
            // Rising-edge capture, zeroed when not loading.
            always_ff @(posedge clk or negedge clr_n) begin
                if (!clr_n) q <= 1'b0;
                else        q <= ld_en ? d : 1'b0;
            end
        end else begin : g_fall
            // Falling-edge capture, zeroed when not loading.
            always_ff @(negedge clk or negedge clr_n) begin
                if (!clr_n) q <= 1'b0;
                else        q <= ld_en ? d : 1'b0;
            end
        end
    endgenerate

endmodule

// File: rtl/deff_ddr_tx.sv
// D-PHY HS DDR output stage: two bits per TX_DDR_clk period onto Dp/Dn,
// first bit on the rising edge, second on the falling edge.
module deff_ddr_tx
    import dphy_pkg::*;
#(
    parameter bit   SWAP_PN = SWAP_PN_DEF,
    parameter logic IDLE_DP = IDLE_DP_DEF,
    parameter logic IDLE_DN = IDLE_DN_DEF
) (
    input  logic TX_DDR_clk,
    input  logic TX_rst,
    input  logic Enable,
    input  logic Serial_B1,
    input  logic Serial_B2,
    output logic Dp,
    output logic Dn
);

    localparam ddr_order_e ORDER = DDR_ORDER;

    logic [1:0] rst_sync;
    logic       srst_n;
    logic       en_q;
    logic       r_p;
    logic       r_n;
    logic       bit_first;
    logic       bit_second;
    logic       d_p;
    logic       d_n;
    logic       d;
    logic       pos;
    logic       drive;

    // Reset synchronizer: asserts immediately, releases on the 2nd posedge.
    always_ff @(posedge TX_DDR_clk or negedge TX_rst) begin
        if (!TX_rst) rst_sync <= 2'b00;
        else         rst_sync <= {rst_sync[0], 1'b1};
    end

    assign srst_n = rst_sync[1];

    // Enable as seen at the last rising edge; qualifies the falling half.
    always_ff @(posedge TX_DDR_clk or negedge srst_n) begin
        if (!srst_n) en_q <= 1'b0;
        else         en_q <= Enable;
    end

    assign bit_first  = (ORDER == B1_FIRST) ? Serial_B1 : Serial_B2;
    assign bit_second = (ORDER == B1_FIRST) ? Serial_B2 : Serial_B1;

    assign d_p = ddr_enc(bit_first, r_n);
    assign d_n = ddr_enc(bit_second, r_p);

    ddr_edge_reg #(.RISE(1'b1)) u_r_p (
        .clk   (TX_DDR_clk),
        .clr_n (srst_n),
        .ld_en (Enable),
        .d     (d_p),
        .q     (r_p)
    );

    ddr_edge_reg #(.RISE(1'b0)) u_r_n (
        .clk   (TX_DDR_clk),
        .clr_n (srst_n),
        .ld_en (en_q),
        .d     (d_n),
        .q     (r_n)
    );

    // Only one of r_p/r_n changes per edge, so the XOR does not glitch.
    assign d   = r_p ^ r_n;
    assign pos = d ^ SWAP_PN;

    // TX_rst gates the pads directly so idle is immediate on assertion.
    assign drive = en_q & srst_n & TX_rst;

    // Output mux: complementary data while driving, idle levels otherwise.
    always_comb begin
        Dp = IDLE_DP;
        Dn = IDLE_DN;
        if (drive) begin
            Dp = pos;
            Dn = ~pos;
        end
    end

endmodule

// File: tb/tb_deff_ddr_tx.sv
`timescale 1ns/1ps
module tb_deff_ddr_tx;

    localparam bit   SWAP = 1'b0;
    localparam logic IDP  = 1'b0;
    localparam logic IDN  = 1'b0;

    logic TX_DDR_clk = 1'b0;
    logic TX_rst     = 1'b0;
    logic Enable     = 1'b0;
    logic Serial_B1  = 1'b0;
    logic Serial_B2  = 1'b0;
    logic Dp, Dn;

    int checks   = 0;
    int failures = 0;
    int sync_left = 2;

    typedef struct {
        logic  dp;
        logic  dn;
        string tag;
    } exp_t;

    exp_t exp_q[$];

    deff_ddr_tx #(.SWAP_PN(SWAP), .IDLE_DP(IDP), .IDLE_DN(IDN)) dut (
        .TX_DDR_clk (TX_DDR_clk),
        .TX_rst     (TX_rst),
        .Enable     (Enable),
        .Serial_B1  (Serial_B1),
        .Serial_B2  (Serial_B2),
        .Dp         (Dp),
        .Dn         (Dn)
    );

    always #5 TX_DDR_clk = ~TX_DDR_clk;

    // Reference: a driven half-bit shows b on Dp (complement on Dn), else idle.
    function automatic exp_t mk(input logic drv, input logic b, input string tag);
        exp_t e;
        e.tag = tag;
        if (drv) begin
            e.dp = b ^ SWAP;
            e.dn = ~(b ^ SWAP);
        end else begin
            e.dp = IDP;
            e.dn = IDN;
        end
        return e;
    endfunction

    // One DDR period. Inputs change in the low phase, before the posedge.
    // A period drives only if reset is out, the synchronizer has released,
    // and Enable is high at its posedge; both halves follow that decision.
    task automatic cycle(input logic en, input logic b1, input logic b2,
                         input string tag, input bit rel = 1'b0);
        logic drv;
        @(negedge TX_DDR_clk);
        #1;
        Enable    = en;
        Serial_B1 = b1;
        Serial_B2 = b2;
        if (rel) begin
            TX_rst    = 1'b1;
            sync_left = 2;
        end
        @(posedge TX_DDR_clk);
        drv = TX_rst && (sync_left == 0) && en;
        if (TX_rst && sync_left > 0) sync_left--;
        exp_q.push_back(mk(drv, b1, tag));
        exp_q.push_back(mk(drv, b2, tag));
    endtask

    task automatic direct_idle(input string tag);
        checks++;
        if (Dp !== IDP || Dn !== IDN) begin
            failures++;
            $display("FAIL %s: Dp=%b Dn=%b, expected Dp=%b Dn=%b", tag, Dp, Dn, IDP, IDN);
        end
    endtask

    // Asserted in the low phase after the last expected half-bit was checked.
    task automatic mid_reset();
        @(negedge TX_DDR_clk);
        #3;
        TX_rst = 1'b0;
        #1;
        direct_idle("mid_reset_immediate");
    endtask

    // Monitor: samples 2 ns after every edge and checks the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge TX_DDR_clk or negedge TX_DDR_clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (Dp !== e.dp || Dn !== e.dn) begin
                    failures++;
                    $display("FAIL %s @%0t: Dp=%b Dn=%b, expected Dp=%b Dn=%b",
                             e.tag, $time, Dp, Dn, e.dp, e.dn);
                end
            end
        end
    end

    initial begin
        #1;
        direct_idle("reset_t0");

        // Reset held with the clock running and busy inputs.
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 1'($urandom), 1'($urandom), "in_reset");
        cycle(1'b0, 1'b1, 1'b1, "release_idle", 1'b1);
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'($urandom), 1'($urandom), "released_disabled");

        // Steady 1/0 pattern.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, "pattern_10");

        // 10, 01, 11, 00 -> 1,0,0,1,1,1,0,0
        cycle(1'b1, 1'b1, 1'b0, "seq_10");
        cycle(1'b1, 1'b0, 1'b1, "seq_01");
        cycle(1'b1, 1'b1, 1'b1, "seq_11");
        cycle(1'b1, 1'b0, 1'b0, "seq_00");

        // Disable, toggle data while disabled, then re-enable.
        cycle(1'b1, 1'b0, 1'b1, "pre_disable");
        cycle(1'b0, 1'b1, 1'b1, "disable");
        cycle(1'b0, 1'b1, 1'b1, "disabled_11");
        cycle(1'b0, 1'b0, 1'b1, "disabled_01");
        cycle(1'b1, 1'b1, 1'b1, "reenable_11");
        cycle(1'b1, 1'b0, 1'b0, "reenable_00");

        // Mid-stream reset, then release and resume.
        cycle(1'b1, 1'b1, 1'b1, "pre_reset");
        mid_reset();
        cycle(1'b1, 1'b1, 1'b0, "held_reset");
        cycle(1'b1, 1'b0, 1'b1, "held_reset");
        cycle(1'b1, 1'b1, 1'b0, "release_sync", 1'b1);
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 1'($urandom), 1'($urandom), "resume");

        // Randomized traffic with Enable high most of the time.
        for (int i = 0; i < 150; i++)
            cycle(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), "random");

        // Second random mid-stream reset.
        mid_reset();
        cycle(1'b1, 1'b1, 1'b1, "release2", 1'b1);
        for (int i = 0; i < 20; i++)
            cycle(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), "random2");

        repeat (3) @(posedge TX_DDR_clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
